// File: rtl/bdpu_pkg.sv
// Shared definitions for the bdpu datapath: default widths common to ram and
// vector_fetch, and the vector_fetch sequencer state encoding.
package bdpu_pkg;

  localparam int VAR_WIDTH_DEF  = 32;
  localparam int ADD_WIDTH_DEF  = 10;
  localparam int PIPE_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } vf_state_t;

endpackage

// File: rtl/vector_fetch.sv
// Read-side sequencer: streams a run of full ram rows out as wide vectors,
// using the ram output register as the holding stage under backpressure.
module vector_fetch
  import bdpu_pkg::*;
#(
  parameter int varWIDTH   = VAR_WIDTH_DEF,
  parameter int ADD_WIDTH  = ADD_WIDTH_DEF,
  parameter int PIPE_WIDTH = PIPE_WIDTH_DEF,
  localparam int ROW_W     = ADD_WIDTH - $clog2(PIPE_WIDTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [ROW_W-1:0]               base_row,
  input  logic [ROW_W:0]                 num_rows,
  output logic                           busy,
  output logic                           done,
  output logic [ADD_WIDTH-1:0]           ram_add,
  output logic                           ram_cs,
  output logic                           ram_oe,
  output logic                           ram_we,
  input  logic [varWIDTH*PIPE_WIDTH-1:0] ram_data_out,
  output logic [varWIDTH*PIPE_WIDTH-1:0] vec_data,
  output logic                           vec_valid,
  input  logic                           vec_ready,
  output logic                           vec_last
);

  localparam int OFF_W = $clog2(PIPE_WIDTH);

  vf_state_t        r_state;
  vf_state_t        w_state_nxt;
  logic [ROW_W-1:0] r_row;
  logic [ROW_W:0]   r_remaining;
  logic             r_vec_valid;
  logic             r_vec_last;
  logic             r_done;
  logic             w_issue;
  logic             w_handshake;
  logic             w_launch;
  logic             w_done_nxt;
  logic             w_rem_one;

  // A new read may only be issued once the ram output register is free to be overwritten.
  always_comb begin
    w_issue     = 1'b0;
    w_handshake = r_vec_valid && vec_ready;
    w_launch    = (r_state == IDLE) && start;
    w_rem_one   = (r_remaining == (ROW_W + 1)'(1));
    if ((r_state == RUN) && (r_remaining != {(ROW_W + 1){1'b0}}) &&
        (!r_vec_valid || vec_ready)) begin
      w_issue = 1'b1;
    end else begin
      w_issue = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (num_rows == {(ROW_W + 1){1'b0}}) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = RUN;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (w_issue && w_rem_one) begin
          w_state_nxt = DRAIN;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DRAIN: begin
        if (w_handshake) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Row pointer wraps naturally at 2^ROW_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row       <= {ROW_W{1'b0}};
      r_remaining <= {(ROW_W + 1){1'b0}};
    end else if (w_launch) begin
      r_row       <= base_row;
      r_remaining <= num_rows;
    end else if (w_issue) begin
      r_row       <= r_row + ROW_W'(1);
      r_remaining <= r_remaining - (ROW_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec_valid <= 1'b0;
      r_vec_last  <= 1'b0;
    end else if (w_issue) begin
      r_vec_valid <= 1'b1;
      r_vec_last  <= w_rem_one;
    end else if (w_handshake) begin
      r_vec_valid <= 1'b0;
      r_vec_last  <= 1'b0;
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign ram_add   = {r_row, {OFF_W{1'b0}}};
  assign ram_cs    = w_issue;
  assign ram_oe    = w_issue;
  assign ram_we    = 1'b0;
  assign vec_data  = ram_data_out;
  assign vec_valid = r_vec_valid;
  assign vec_last  = r_vec_last;

endmodule

// File: tb/tb_vector_fetch.sv
// Directed bench for vector_fetch with a behavioural ram and a row-level
// expectation model checked every cycle, plus literal cycle-by-cycle pins.
module tb_vector_fetch;

  localparam int VW = 32;
  localparam int AW = 10;
  localparam int PW = 16;
  localparam int RW = 6;
  localparam int DW = VW * PW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [RW-1:0] base_row;
  logic [RW:0]   num_rows;
  logic          busy, done, ram_cs, ram_oe, ram_we, vec_valid, vec_ready, vec_last;
  logic [AW-1:0] ram_add;
  logic [DW-1:0] ram_data_out, vec_data;

  vector_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_row(base_row), .num_rows(num_rows),
    .busy(busy), .done(done), .ram_add(ram_add), .ram_cs(ram_cs), .ram_oe(ram_oe),
    .ram_we(ram_we), .ram_data_out(ram_data_out), .vec_data(vec_data),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_last(vec_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int done_cnt = 0;
  bit done_pending = 1'b0;
  int exp_issue[$];
  int exp_row[$];
  bit exp_last[$];
  bit stall_prev = 1'b0;
  logic [DW-1:0] stall_data;

  logic          tr_cs[0:2047];
  logic [AW-1:0] tr_add[0:2047];
  logic          tr_valid[0:2047];
  logic          tr_last[0:2047];
  logic          tr_done[0:2047];
  logic          tr_busy[0:2047];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Ram contents: word i of the 16-word line at address a holds C0DE0000 | (a+i).
  function automatic logic [DW-1:0] ram_line(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    for (int i = 0; i < PW; i++) v[i*VW +: VW] = 32'hC0DE0000 | (32'(a) + 32'(i));
    return v;
  endfunction

  // What row r must look like on the vector stream.
  function automatic logic [DW-1:0] row_vec(input int r);
    logic [DW-1:0] v;
    for (int i = 0; i < PW; i++) v[i*VW +: VW] = 32'hC0DE0000 + 32'(r * PW + i);
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (ram_cs && ram_oe && !ram_we) ram_data_out <= ram_line(ram_add);

  always @(negedge clk) begin
    if (cyc < 2048) begin
      tr_cs[cyc]    <= ram_cs;
      tr_add[cyc]   <= ram_add;
      tr_valid[cyc] <= vec_valid;
      tr_last[cyc]  <= vec_last;
      tr_done[cyc]  <= done;
      tr_busy[cyc]  <= busy;
    end
  end

  // Compare process: every active cycle against the row-level model.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      chk("ram_we_zero", 64'(ram_we), 64'd0);
      chk("ram_oe_eq_cs", 64'(ram_oe), 64'(ram_cs));
      if (ram_cs) begin
        if (exp_issue.size() == 0) chk("unexpected_issue", 64'd1, 64'd0);
        else chk("ram_add", 64'(ram_add), 64'(exp_issue.pop_front() * PW));
      end
      if (vec_valid && !vec_ready) begin
        chk("stall_oe_low", 64'(ram_oe), 64'd0);
        if (stall_prev) chk_vec("stall_hold", vec_data, stall_data);
        stall_data = vec_data;
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
      if (vec_valid && vec_ready) begin
        if (exp_row.size() == 0) chk("unexpected_vec", 64'd1, 64'd0);
        else begin
          chk_vec("vec_data", vec_data, row_vec(exp_row.pop_front()));
          chk("vec_last", 64'(vec_last), 64'(exp_last.pop_front()));
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_expected", 64'(done_pending), 64'd1);
        chk("done_all_delivered", 64'(exp_row.size()), 64'd0);
        chk("done_not_busy", 64'(busy), 64'd0);
        done_pending = 1'b0;
      end
    end
  end

  task automatic launch(input int b, input int n);
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b1; base_row = RW'(b); num_rows = (RW + 1)'(n); vec_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_issue.push_back((b + i) % 64);
      exp_row.push_back((b + i) % 64);
      exp_last.push_back(i == n - 1);
    end
    done_pending = 1'b1;
  endtask

  // Runs one transfer; vec_ready low in cycles slo..shi, stray start at cycle mis_k.
  task automatic run(input int b, input int n, input int slo, input int shi, input int mis_k);
    int d0;
    bit got;
    d0 = done_cnt;
    got = 1'b0;
    launch(b, n);
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clk); #1;
      if (done_cnt != d0) got = 1'b1;
      else begin
        start = (k == mis_k);
        if (k == mis_k) begin base_row = 6'd33; num_rows = 7'd5; end
        vec_ready = !(k >= slo && k <= shi);
      end
    end
    start = 1'b0; vec_ready = 1'b1;
    chk("run_completed", 64'(got), 64'd1);
    chk("single_done", 64'(done_cnt - d0), 64'd1);
    @(negedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_row = 6'd0; num_rows = 7'd0; vec_ready = 1'b1;
    ram_data_out = '0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(vec_valid), 64'd0);
    chk("rst_last", 64'(vec_last), 64'd0);
    chk("rst_cs", 64'(ram_cs), 64'd0);
    chk("rst_oe", 64'(ram_oe), 64'd0);
    chk("rst_add", 64'(ram_add), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Back-to-back run
    run(0, 4, 100, 0, 0);
    chk("b2b_add1", 64'(tr_add[t0+1]), 64'd0);
    chk("b2b_add2", 64'(tr_add[t0+2]), 64'd16);
    chk("b2b_add3", 64'(tr_add[t0+3]), 64'd32);
    chk("b2b_add4", 64'(tr_add[t0+4]), 64'd48);
    chk("b2b_cs1_4", 64'({tr_cs[t0+1], tr_cs[t0+2], tr_cs[t0+3], tr_cs[t0+4], tr_cs[t0+5]}), 64'b11110);
    chk("b2b_valid", 64'({tr_valid[t0+1], tr_valid[t0+2], tr_valid[t0+3], tr_valid[t0+4],
                          tr_valid[t0+5], tr_valid[t0+6]}), 64'b011110);
    chk("b2b_last", 64'({tr_last[t0+4], tr_last[t0+5], tr_last[t0+6]}), 64'b010);
    chk("b2b_done", 64'({tr_done[t0+5], tr_done[t0+6], tr_done[t0+7]}), 64'b010);
    chk("b2b_busy", 64'({tr_busy[t0+0], tr_busy[t0+1], tr_busy[t0+5], tr_busy[t0+6]}), 64'b0110);

    // Backpressure in cycles 3..5
    run(0, 4, 3, 5, 0);
    chk("bp_cs_stall", 64'({tr_cs[t0+3], tr_cs[t0+4], tr_cs[t0+5]}), 64'b000);
    chk("bp_add6", 64'(tr_add[t0+6]), 64'd32);
    chk("bp_add7", 64'(tr_add[t0+7]), 64'd48);
    chk("bp_last8", 64'(tr_last[t0+8]), 64'd1);
    chk("bp_done", 64'({tr_done[t0+8], tr_done[t0+9], tr_done[t0+10]}), 64'b010);

    // Zero-length run
    run(7, 0, 100, 0, 0);
    chk("zero_done1", 64'(tr_done[t0+1]), 64'd1);
    chk("zero_busy1", 64'(tr_busy[t0+1]), 64'd0);
    chk("zero_no_cs", 64'({tr_cs[t0+0], tr_cs[t0+1], tr_cs[t0+2]}), 64'b000);

    // Wrap-around
    run(62, 3, 100, 0, 0);
    chk("wrap_add1", 64'(tr_add[t0+1]), 64'd992);
    chk("wrap_add2", 64'(tr_add[t0+2]), 64'd1008);
    chk("wrap_add3", 64'(tr_add[t0+3]), 64'd0);

    // Stray start while busy, with a late stall around the last row
    run(20, 3, 4, 5, 2);
    chk("misuse_add2", 64'(tr_add[t0+2]), 64'd336);

    // Reset in the middle of a run
    launch(10, 8);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(vec_valid), 64'd0);
    chk("mid_rst_last", 64'(vec_last), 64'd0);
    chk("mid_rst_cs", 64'(ram_cs), 64'd0);
    chk("mid_rst_oe", 64'(ram_oe), 64'd0);
    chk("mid_rst_add", 64'(ram_add), 64'd0);
    exp_issue.delete(); exp_row.delete(); exp_last.delete();
    done_pending = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_done", 64'(done), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_done", 64'(done), 64'd0);
    run(5, 2, 100, 0, 0);
    chk("post_rst_add1", 64'(tr_add[t0+1]), 64'd80);
    chk("post_rst_done", 64'(tr_done[t0+4]), 64'd1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_fetch.md
# vector_fetch

Read-side sequencer that sits directly downstream of the banked `ram` block. It pulls a programmed run of full rows, each `PIPE_WIDTH` words wide, out of the `ram` and presents each row as one wide vector on a valid/ready stream to the compute array. It owns the `ram` read controls, and it absorbs downstream backpressure by using the `ram` output register as its holding stage.

## Interface
Parameters:
- `varWIDTH`, 32, bits per word (must match `ram`)
- `ADD_WIDTH`, 10, `ram` word-address width
- `PIPE_WIDTH`, 16, words per row, power of two
- `ROW_W` (localparam), `ADD_WIDTH - $clog2(PIPE_WIDTH)`, row-index width

Ports:
- `clk`  in  1  sole clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  launch a run; sampled only in IDLE
- `base_row`  in  ROW_W  first row index, sampled with `start`
- `num_rows`  in  ROW_W+1  row count, 0..2^ROW_W, sampled with `start`
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse at end of run
- `ram_add`  out  ADD_WIDTH  `{row, {log2(PIPE_WIDTH){0}}}`
- `ram_cs`, `ram_oe`  out  1  high only on an issue cycle
- `ram_we`  out  1  constant 0
- `ram_data_out`  in  varWIDTH*PIPE_WIDTH  from `ram`
- `vec_data`  out  varWIDTH*PIPE_WIDTH  equals `ram_data_out`; meaningful only while `vec_valid`
- `vec_valid`  out  1  vector available
- `vec_ready`  in  1  downstream accepts
- `vec_last`  out  1  qualifies the final vector of the run

## Operation
- States:
  - IDLE:
    - `start` latches `base_row` into the row pointer and `num_rows` into the remaining-issue counter.
    - If `num_rows` == 0, the next state is IDLE and `done` pulses; otherwise the next state is RUN.
  - RUN:
    - The block issues reads while the remaining count is > 0.
    - When the count reaches 0 after the last issue, the next state is DRAIN.
  - DRAIN:
    - The block waits for the final handshake, then goes to IDLE and pulses `done`.
- Issue condition: `state==RUN && remaining!=0 && (!vec_valid || vec_ready)`.
  - On an issue, `ram_cs = ram_oe = 1` and `ram_add` comes from the row pointer.
  - The row pointer increments modulo 2^ROW_W, so it wraps from the last row to row 0.
  - `remaining` decrements on each issue.
- `vec_valid`:
  - Set on the cycle after an issue.
  - Cleared after a handshake (`vec_valid && vec_ready`) with no issue in the same cycle.
- `vec_last` is registered. It is set with `vec_valid` when the issue carried `remaining==1`, and cleared on the handshake.
- While `vec_valid && !vec_ready`, `ram_oe` stays low, so the `ram` output register, and therefore `vec_data`, holds stable. No row is dropped or duplicated.
- `start` is ignored outside IDLE. It is accepted in the same cycle that `done` pulses, because the state is already IDLE.
- Reset asynchronously clears everything:
  - state = IDLE
  - `busy`, `done`, `vec_valid`, `vec_last` = 0
  - `ram_cs`, `ram_oe`, `ram_we` = 0
  - `ram_add` = 0
  - counters = 0
- When reset is asserted mid-run, the run is abandoned. No `done` pulse is produced.

## Timing
- `start` sampled at edge 0 → first issue in cycle 1 → `vec_valid` in cycle 2.
- Read latency is 1 cycle, matching the `ram` registered read.
- Throughput is 1 row per cycle while `vec_ready` stays high.
- The final handshake happens in cycle N. In cycle N+1, `done=1` and `busy=0`.
- Outputs `ram_*`, `vec_valid`, `vec_last`, `done` and `busy` are driven from registers or decoded from state. `ram_cs`/`ram_oe` are combinational from the issue condition.

## Structure
- Shared package `bdpu_pkg` holds:
  - state enum `vf_state_t` (IDLE/RUN/DRAIN)
  - default width constants, shared with `ram`
- Single module, no sub-module. The counter and the pointer are small enough to inline.

## Test plan
- Back-to-back run:
  - Stimulus: `base_row=0`, `num_rows=4`, `vec_ready=1`.
  - `ram_add` = 0, 16, 32, 48 in cycles 1–4.
  - `vec_valid` high in cycles 2–5, `vec_last` in cycle 5.
  - `done` in cycle 6.
- Backpressure:
  - Stimulus: same run with `vec_ready=0` in cycles 3–5.
  - `ram_oe` low during the stall.
  - `vec_data` is unchanged during the stall.
  - All 4 rows are delivered in order, and `done` arrives 3 cycles later.
- Zero-length run:
  - Stimulus: `num_rows=0`.
  - `done` in cycle 1, and `ram_cs` never goes high.
- Wrap-around:
  - Stimulus: `ROW_W=6`, `base_row=62`, `num_rows=3`.
  - `ram_add` = 992, 1008, 0.
- Misuse and reset:
  - Stimulus 1: pulse `start` while `busy`.
    - Response: no effect.
  - Stimulus 2: drop `rst_n` in the middle of the run.
    - Response: all outputs go to 0 immediately and no `done` is produced.
    - After `rst_n` returns, a new `start` runs normally.
